cpu_store_buffer: RTL and testbench

- Write-direction counterpart of the writeback load path: accepts stores (SB/SH/SW) from the memory stage and formats rs2 data into a word-aligned bus write with byte strobes.
- Queues formatted stores in a small FIFO and drains them to the data-memory bus over a req/ack handshake, so stores do not stall the pipeline unless the buffer is full.
- Flags misaligned or illegal stores.
- Provides a word-address hazard check so the load path can stall on a pending store to the same word.

---
 rtl/cpu_store_buffer.sv | 199 +++++++++++++++++++
 tb/tb_cpu_store_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_store_buffer.sv
// cpu_store_buffer: accepts SB/SH/SW stores from the memory stage, formats
// them into word-aligned bus writes with byte strobes, queues them in a small
// FIFO and drains them to data memory over a req/ack handshake. Misaligned or
// illegal stores are consumed but dropped and reported with a one-cycle
// st_err_o pulse. A word-address compare lets the load path stall on a
// pending store to the same word.

module cpu_store_buffer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        st_valid_i,
    output logic        st_ready_o,
    input  logic [31:0] st_addr_i,
    input  logic [31:0] st_data_i,
    input  logic [2:0]  st_funct3_i,
    output logic        st_err_o,
    output logic [31:0] err_addr_o,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_ack_i,
    input  logic [31:0] ld_addr_i,
    output logic        ld_hazard_o,
    output logic        sb_empty_o
);

    // Pointer width indexes DEPTH entries; the count needs one more bit so
    // that "full" (count == DEPTH) is representable.
    localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    typedef enum logic [1:0] {
        WidthByte = 2'b00,
        WidthHalf = 2'b01,
        WidthWord = 2'b10
    } storeWidth_e;

    // Queue storage: the word address is kept without its two low bits since
    // every bus write is word-aligned.
    logic [29:0]   entryAddr_q  [DEPTH];
    logic [31:0]   entryData_q  [DEPTH];
    logic [3:0]    entryStrb_q  [DEPTH];
    logic [DEPTH-1:0] entryValid_q, entryValid_d;

    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;

    logic          stErr_q, stErr_d;
    logic [31:0]   errAddr_q, errAddr_d;

    logic [31:0]   fmtData;
    logic [3:0]    fmtStrb;
    logic          fmtBad;

    logic          accept;
    logic          push;
    logic          pop;
    logic          busReq;

    // The low two bits of the load address never matter for a word compare.
    logic          unusedLdLow;
    assign unusedLdLow = ^ld_addr_i[1:0];

    // Handshake qualifiers: a rejected store is still consumed but never
    // pushed, and a pop only happens while a write is actually presented.
    always_comb begin
        st_ready_o = (count_q != FullCount);
        busReq     = (count_q != '0);
        accept     = st_valid_i && st_ready_o;
        push       = accept && !fmtBad;
        pop        = busReq && bus_ack_i;
    end

    // Lane replication and strobe generation for the incoming store, plus
    // detection of misaligned or unsupported widths.
    always_comb begin
        fmtData = '0;
        fmtStrb = '0;
        fmtBad  = 1'b0;
        case (st_funct3_i)
            {1'b0, WidthByte}: begin
                fmtData = {4{st_data_i[7:0]}};
                fmtStrb = 4'b0001 << st_addr_i[1:0];
            end
            {1'b0, WidthHalf}: begin
                fmtData = {2{st_data_i[15:0]}};
                fmtStrb = st_addr_i[1] ? 4'b1100 : 4'b0011;
                fmtBad  = st_addr_i[0];
            end
            {1'b0, WidthWord}: begin
                fmtData = st_data_i;
                fmtStrb = 4'b1111;
                fmtBad  = (st_addr_i[1:0] != 2'b00);
            end
            default: begin
                fmtBad  = 1'b1;
            end
        endcase
    end

    // Next-state for pointers, occupancy, per-entry valid bits and the error
    // reporting registers. Push and pop never target the same slot because a
    // push needs a non-full queue and a pop needs a non-empty one.
    always_comb begin
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        count_d      = count_q;
        entryValid_d = entryValid_q;
        stErr_d      = accept && fmtBad;
        errAddr_d    = errAddr_q;

        if (accept && fmtBad) begin
            errAddr_d = st_addr_i;
        end

        if (push) begin
            wrPtr_d               = wrPtr_q + PW'(1);
            entryValid_d[wrPtr_q] = 1'b1;
        end

        if (pop) begin
            rdPtr_d               = rdPtr_q + PW'(1);
            entryValid_d[rdPtr_q] = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset; a reset discards every
    // queued entry, including the one currently on the bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            entryValid_q <= '0;
            stErr_q      <= 1'b0;
            errAddr_q    <= '0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            count_q      <= count_d;
            entryValid_q <= entryValid_d;
            stErr_q      <= stErr_d;
            errAddr_q    <= errAddr_d;
        end
    end

    // Payload storage needs no reset; entries are only observed while valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            entryAddr_q[wrPtr_q] <= st_addr_i[31:2];
            entryData_q[wrPtr_q] <= fmtData;
            entryStrb_q[wrPtr_q] <= fmtStrb;
        end
    end

    // Bus presentation straight from the head slot, forced to zero when idle
    // so the bus never shows stale data.
    always_comb begin
        bus_req_o   = busReq;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        bus_wstrb_o = '0;
        if (busReq) begin
            bus_addr_o  = {entryAddr_q[rdPtr_q], 2'b00};
            bus_wdata_o = entryData_q[rdPtr_q];
            bus_wstrb_o = entryStrb_q[rdPtr_q];
        end
    end

    // Word-granular hazard against every queued store, including the one on
    // the bus; a store being accepted this cycle is not yet visible here.
    always_comb begin
        ld_hazard_o = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (entryValid_q[i] && (entryAddr_q[i] == ld_addr_i[31:2])) begin
                ld_hazard_o = 1'b1;
            end
        end
    end

    // Status outputs.
    always_comb begin
        st_err_o   = stErr_q;
        err_addr_o = errAddr_q;
        sb_empty_o = (count_q == '0);
    end

endmodule

// File: tb/tb_cpu_store_buffer.sv
// Directed testbench for cpu_store_buffer (DEPTH=2). Inputs change 1ns after
// each rising edge; outputs are sampled 1ns later, well away from the edge.

module tb_cpu_store_buffer;

    logic        clk;
    logic        rst;
    logic        stValid;
    logic        stReady;
    logic [31:0] stAddr;
    logic [31:0] stData;
    logic [2:0]  stFunct3;
    logic        stErr;
    logic [31:0] errAddr;
    logic        busReq;
    logic [31:0] busAddr;
    logic [31:0] busWdata;
    logic [3:0]  busWstrb;
    logic        busAck;
    logic [31:0] ldAddr;
    logic        ldHazard;
    logic        sbEmpty;

    int checks   = 0;
    int failures = 0;

    cpu_store_buffer #(.DEPTH(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .st_valid_i  (stValid),
        .st_ready_o  (stReady),
        .st_addr_i   (stAddr),
        .st_data_i   (stData),
        .st_funct3_i (stFunct3),
        .st_err_o    (stErr),
        .err_addr_o  (errAddr),
        .bus_req_o   (busReq),
        .bus_addr_o  (busAddr),
        .bus_wdata_o (busWdata),
        .bus_wstrb_o (busWstrb),
        .bus_ack_i   (busAck),
        .ld_addr_i   (ldAddr),
        .ld_hazard_o (ldHazard),
        .sb_empty_o  (sbEmpty)
    );

    // 10ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] funct3,
                                 input logic [31:0] addr, input logic [31:0] data);
        stValid  = valid;
        stFunct3 = funct3;
        stAddr   = addr;
        stData   = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        busAck = 1'b0;
        ldAddr = 32'h0;
        applyStimulus(1'b0, 3'b010, 32'h0, 32'h0);

        // ---------------- reset state ----------------
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rst_ready",  32'(stReady),  32'd1);
        checkOutput("rst_empty",  32'(sbEmpty),  32'd1);
        checkOutput("rst_busreq", 32'(busReq),   32'd0);
        checkOutput("rst_err",    32'(stErr),    32'd0);
        checkOutput("rst_erraddr", errAddr,      32'h0);
        checkOutput("rst_hazard", 32'(ldHazard), 32'd0);
        checkOutput("rst_busaddr", busAddr,      32'h0);
        checkOutput("rst_wstrb",  32'(busWstrb), 32'h0);

        // ---------------- SW 0x100, ack next cycle ----------------
        applyStimulus(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        checkOutput("sw_busreq", 32'(busReq),   32'd1);
        checkOutput("sw_addr",   busAddr,       32'h100);
        checkOutput("sw_wdata",  busWdata,      32'hDEADBEEF);
        checkOutput("sw_wstrb",  32'(busWstrb), 32'hF);
        checkOutput("sw_notempty", 32'(sbEmpty), 32'd0);
        busAck = 1'b1;
        tick();
        busAck = 1'b0;
        #1;
        checkOutput("sw_empty_after_ack", 32'(sbEmpty), 32'd1);
        checkOutput("sw_busreq_after_ack", 32'(busReq), 32'd0);
        checkOutput("sw_idle_wdata", busWdata, 32'h0);

        // ---------------- SB 0x203 then SH 0x302, in order ----------------
        applyStimulus(1'b1, 3'b000, 32'h203, 32'h000000A5);
        tick();
        applyStimulus(1'b1, 3'b001, 32'h302, 32'h00001234);
        tick();
        applyStimulus(1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        checkOutput("sb_addr",  busAddr,       32'h200);
        checkOutput("sb_wdata", busWdata,      32'hA5A5A5A5);
        checkOutput("sb_wstrb", 32'(busWstrb), 32'h8);
        checkOutput("sb_full_ready", 32'(stReady), 32'd0);
        busAck = 1'b1;
        tick();
        checkOutput("sh_addr",  busAddr,       32'h300);
        checkOutput("sh_wdata", busWdata,      32'h12341234);
        checkOutput("sh_wstrb", 32'(busWstrb), 32'hC);
        tick();
        busAck = 1'b0;
        #1;
        checkOutput("sbsh_empty", 32'(sbEmpty), 32'd1);

        // ---------------- rejected stores ----------------
        applyStimulus(1'b1, 3'b010, 32'h101, 32'h11111111);
        tick();
        applyStimulus(1'b1, 3'b001, 32'h001, 32'h22222222);
        #1;
        checkOutput("err1_pulse", 32'(stErr),  32'd1);
        checkOutput("err1_addr",  errAddr,     32'h101);
        checkOutput("err1_busreq", 32'(busReq), 32'd0);
        tick();
        applyStimulus(1'b1, 3'b011, 32'h555, 32'h33333333);
        #1;
        checkOutput("err2_pulse", 32'(stErr),  32'd1);
        checkOutput("err2_addr",  errAddr,     32'h001);
        tick();
        applyStimulus(1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        checkOutput("err3_pulse", 32'(stErr),  32'd1);
        checkOutput("err3_addr",  errAddr,     32'h555);
        checkOutput("err3_empty", 32'(sbEmpty), 32'd1);
        tick();
        checkOutput("err_pulse_end", 32'(stErr), 32'd0);
        checkOutput("err_addr_hold", errAddr,    32'h555);
        checkOutput("err_busreq",   32'(busReq), 32'd0);

        // ---------------- full FIFO, back-pressure, pointer wrap ----------------
        applyStimulus(1'b1, 3'b010, 32'h10, 32'hD1D1D1D1);
        tick();
        applyStimulus(1'b1, 3'b010, 32'h14, 32'hD2D2D2D2);
        tick();
        applyStimulus(1'b1, 3'b010, 32'h18, 32'hD3D3D3D3);
        #1;
        checkOutput("full_ready", 32'(stReady), 32'd0);
        tick();
        checkOutput("full_held_ready", 32'(stReady), 32'd0);
        checkOutput("full_head", busAddr, 32'h10);
        busAck = 1'b1;
        tick();
        busAck = 1'b0;
        #1;
        checkOutput("pop_ready_no_passthru", 32'(stReady), 32'd1);
        checkOutput("pop_head2", busAddr, 32'h14);
        tick();
        applyStimulus(1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        checkOutput("wrap_ready", 32'(stReady), 32'd0);
        checkOutput("wrap_head2_data", busWdata, 32'hD2D2D2D2);
        busAck = 1'b1;
        tick();
        checkOutput("wrap_head3_addr", busAddr,  32'h18);
        checkOutput("wrap_head3_data", busWdata, 32'hD3D3D3D3);
        tick();
        busAck = 1'b0;
        #1;
        checkOutput("wrap_empty", 32'(sbEmpty), 32'd1);

        // ---------------- load hazard ----------------
        ldAddr = 32'h400;
        applyStimulus(1'b1, 3'b010, 32'h400, 32'hCAFEF00D);
        #1;
        checkOutput("haz_same_cycle", 32'(ldHazard), 32'd0);
        tick();
        applyStimulus(1'b0, 3'b010, 32'h0, 32'h0);
        ldAddr = 32'h402;
        #1;
        checkOutput("haz_same_word", 32'(ldHazard), 32'd1);
        ldAddr = 32'h404;
        #1;
        checkOutput("haz_next_word", 32'(ldHazard), 32'd0);
        ldAddr = 32'h402;
        busAck = 1'b1;
        tick();
        busAck = 1'b0;
        #1;
        checkOutput("haz_after_pop", 32'(ldHazard), 32'd0);

        // ---------------- reset mid-operation ----------------
        applyStimulus(1'b1, 3'b010, 32'h500, 32'h55555555);
        tick();
        applyStimulus(1'b1, 3'b010, 32'h504, 32'h66666666);
        tick();
        applyStimulus(1'b0, 3'b010, 32'h0, 32'h0);
        ldAddr = 32'h500;
        #1;
        checkOutput("pre_rst_busreq", 32'(busReq), 32'd1);
        checkOutput("pre_rst_hazard", 32'(ldHazard), 32'd1);
        rst = 1'b1;
        busAck = 1'b1;
        tick();
        rst = 1'b0;
        busAck = 1'b0;
        #1;
        checkOutput("mid_rst_busreq", 32'(busReq),   32'd0);
        checkOutput("mid_rst_empty",  32'(sbEmpty),  32'd1);
        checkOutput("mid_rst_err",    32'(stErr),    32'd0);
        checkOutput("mid_rst_ready",  32'(stReady),  32'd1);
        checkOutput("mid_rst_erraddr", errAddr,      32'h0);
        checkOutput("mid_rst_hazard", 32'(ldHazard), 32'd0);
        checkOutput("mid_rst_busaddr", busAddr,      32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
